// File: rtl/aes_text_out_unloader.sv
// Captures the 128-bit cipher result on done and streams it out
// as WORD_W-bit words, most-significant word first, over valid/ready.
module aes_text_out_unloader #(
    parameter int BLOCK_W = 128,
    parameter int WORD_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               done,
    input  logic [BLOCK_W-1:0] text_out,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               overrun,
    input  logic               ovr_clr
);

    localparam int NWORDS = BLOCK_W / WORD_W;
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic   [CW-1:0]                 cnt_q, cnt_d;
    logic   [BLOCK_W-1:0]            hold_q, hold_d;
    logic                            ovr_q, ovr_d;
    logic   [NWORDS-1:0][WORD_W-1:0] words;
    logic                            sending;
    logic                            is_last;
    logic                            hs;

    // Packed view: highest index is the most-significant word (word 0).
    assign words   = hold_q;
    assign sending = (state_q == SEND);
    assign is_last = (cnt_q == LAST);
    assign hs      = sending && out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        ovr_d   = ovr_q;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (done) begin
                    hold_d  = text_out;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs && is_last) begin
                    cnt_d = '0;
                    // A done coinciding with the final handshake chains
                    // straight into the next block without a bubble.
                    if (done) begin
                        hold_d = text_out;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (hs) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (done) begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_valid = sending;
    assign busy      = sending;
    assign out_last  = sending && is_last;
    assign out_data  = sending ? words[LAST - cnt_q] : '0;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_aes_text_out_unloader.sv
// Directed bench for aes_text_out_unloader: reset, streaming,
// backpressure, back-to-back, overrun and a 64-bit word instance.
module tb_aes_text_out_unloader;

    logic         clk;
    logic         rst;
    logic         done;
    logic [127:0] text_out;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic         overrun;
    logic         ovr_clr;

    logic         done64;
    logic         ready64;
    logic [63:0]  data64;
    logic         valid64;
    logic         last64;
    logic         busy64;
    logic         ovr64;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] BLK_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;

    logic [31:0] wa [4];
    logic [31:0] wb [4];

    aes_text_out_unloader #(.BLOCK_W(128), .WORD_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .text_out  (text_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    aes_text_out_unloader #(.BLOCK_W(128), .WORD_W(64)) dut64 (
        .clk       (clk),
        .rst       (rst),
        .done      (done64),
        .text_out  (text_out),
        .out_data  (data64),
        .out_valid (valid64),
        .out_ready (ready64),
        .out_last  (last64),
        .busy      (busy64),
        .overrun   (ovr64),
        .ovr_clr   (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        done = 1'b0;
        text_out = '0;
        out_ready = 1'b0;
        ovr_clr = 1'b0;
        done64 = 1'b0;
        ready64 = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 ||
            overrun !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got v=%b b=%b l=%b o=%b d=%h want 0",
                     out_valid, busy, out_last, overrun, out_data);
        end
        rst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got v=%b b=%b want 0 0",
                     out_valid, busy);
        end
    endtask

    task automatic test_basic();
        done = 1'b1;
        text_out = BLK_A;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            done = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== wa[i] ||
                out_last !== (i == 3)) begin
                errors++;
                $display("FAIL basic_word%0d got v=%b b=%b d=%h l=%b want 1 1 %h %b",
                         i, out_valid, busy, out_data, out_last, wa[i], (i == 3));
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL basic_end got v=%b b=%b d=%h want 0 0 0",
                     out_valid, busy, out_data);
        end
    endtask

    task automatic test_backpressure();
        done = 1'b1;
        text_out = BLK_A;
        out_ready = 1'b0;
        step();
        done = 1'b0;
        checks++;
        if (out_data !== wa[0] || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_word0 got d=%h v=%b want %h 1",
                     out_data, out_valid, wa[0]);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_data !== wa[1] || out_valid !== 1'b1 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got d=%h v=%b l=%b want %h 1 0",
                         i, out_data, out_valid, out_last, wa[1]);
            end
        end
        out_ready = 1'b1;
        for (int i = 2; i < 4; i++) begin
            step();
            checks++;
            if (out_data !== wa[i] || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL bp_resume%0d got d=%h l=%b want %h %b",
                         i, out_data, out_last, wa[i], (i == 3));
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        done = 1'b1;
        text_out = BLK_A;
        out_ready = 1'b1;
        step();
        done = 1'b0;
        step();
        step();
        step();
        checks++;
        if (out_data !== wa[3] || out_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_lastA got d=%h l=%b want %h 1",
                     out_data, out_last, wa[3]);
        end
        done = 1'b1;
        text_out = BLK_B;
        for (int i = 0; i < 4; i++) begin
            step();
            done = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== wb[i] ||
                out_last !== (i == 3) || overrun !== 1'b0) begin
                errors++;
                $display("FAIL b2b_wordB%0d got v=%b d=%h l=%b o=%b want 1 %h %b 0",
                         i, out_valid, out_data, out_last, overrun, wb[i], (i == 3));
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got v=%b b=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_overrun();
        done = 1'b1;
        text_out = BLK_A;
        out_ready = 1'b1;
        step();
        done = 1'b0;
        step();
        checks++;
        if (out_data !== wa[1] || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_pre got d=%h o=%b want %h 0",
                     out_data, overrun, wa[1]);
        end
        done = 1'b1;
        text_out = BLK_B;
        for (int i = 2; i < 4; i++) begin
            step();
            done = 1'b0;
            checks++;
            if (out_data !== wa[i] || overrun !== 1'b1 || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL ovr_word%0d got d=%h o=%b l=%b want %h 1 %b",
                         i, out_data, overrun, out_last, wa[i], (i == 3));
            end
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || overrun !== 1'b1) begin
                errors++;
                $display("FAIL ovr_idle%0d got v=%b o=%b want 0 1",
                         i, out_valid, overrun);
            end
        end
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear got %b want 0", overrun);
        end
        done = 1'b1;
        text_out = BLK_A;
        step();
        done = 1'b1;
        text_out = BLK_B;
        ovr_clr = 1'b1;
        step();
        done = 1'b0;
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b1 || out_data !== wa[1]) begin
            errors++;
            $display("FAIL ovr_set_wins got o=%b d=%h want 1 %h",
                     overrun, out_data, wa[1]);
        end
        step();
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_drain got v=%b want 0", out_valid);
        end
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
    endtask

    task automatic test_reset_mid_send();
        done = 1'b1;
        text_out = BLK_A;
        out_ready = 1'b1;
        step();
        done = 1'b0;
        step();
        step();
        checks++;
        if (out_data !== wa[2]) begin
            errors++;
            $display("FAIL rst_mid_pre got d=%h want %h", out_data, wa[2]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_async got v=%b b=%b d=%h want 0 0 0",
                     out_valid, busy, out_data);
        end
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
                out_data !== 32'h0) begin
                errors++;
                $display("FAIL rst_mid_after%0d got v=%b b=%b o=%b d=%h want 0 0 0 0",
                         i, out_valid, busy, overrun, out_data);
            end
        end
    endtask

    task automatic test_word64();
        done64 = 1'b1;
        text_out = BLK_A;
        ready64 = 1'b1;
        step();
        done64 = 1'b0;
        checks++;
        if (valid64 !== 1'b1 || data64 !== 64'h69c4e0d86a7b0430 || last64 !== 1'b0) begin
            errors++;
            $display("FAIL w64_word0 got v=%b d=%h l=%b want 1 69c4e0d86a7b0430 0",
                     valid64, data64, last64);
        end
        step();
        checks++;
        if (valid64 !== 1'b1 || data64 !== 64'hd8cdb78070b4c55a || last64 !== 1'b1) begin
            errors++;
            $display("FAIL w64_word1 got v=%b d=%h l=%b want 1 d8cdb78070b4c55a 1",
                     valid64, data64, last64);
        end
        step();
        checks++;
        if (valid64 !== 1'b0 || busy64 !== 1'b0 || ovr64 !== 1'b0) begin
            errors++;
            $display("FAIL w64_end got v=%b b=%b o=%b want 0 0 0",
                     valid64, busy64, ovr64);
        end
    endtask

    initial begin
        wa[0] = 32'h69c4e0d8;
        wa[1] = 32'h6a7b0430;
        wa[2] = 32'hd8cdb780;
        wa[3] = 32'h70b4c55a;
        wb[0] = 32'h00112233;
        wb[1] = 32'h44556677;
        wb[2] = 32'h8899aabb;
        wb[3] = 32'hccddeeff;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_mid_send();
        test_word64();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_text_out_unloader.md
Name: aes_text_out_unloader

Overview:
Output-side counterpart to the cipher core's 128-bit text_in load register. The core loads a full block in parallel; this block captures the 128-bit text_out result when the core pulses done. It then streams the result out as WORD_W-bit words over a valid/ready handshake, most-significant word first. It sits between aes_cipher_top and the downstream word-wide consumer, and reports busy so the host can hold off the next ld.

Parameters:
BLOCK_W, 128, block width in bits; fixed at 128 for AES.
WORD_W, 32, output word width; must divide BLOCK_W; NWORDS = BLOCK_W/WORD_W (4 by default).

Ports:
clk  input  1  core clock; all state on rising edge.
rst  input  1  asynchronous, active-low reset.
done  input  1  single-cycle pulse from cipher core; text_out is valid in the same cycle.
text_out  input  BLOCK_W  cipher result; sampled only when done=1 is accepted.
out_data  output  WORD_W  current word; stable while out_valid=1 and out_ready=0.
out_valid  output  1  word available.
out_ready  input  1  consumer accepts the word; handshake = out_valid & out_ready.
out_last  output  1  high with the final word (index NWORDS-1) of a block.
busy  output  1  high while a block is held or being sent.
overrun  output  1  sticky: done arrived while the previous block was not drained.
ovr_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst=0, asynchronous) drives the following values, held while rst=0:
  - state=IDLE, word counter=0, holding register=0.
  - out_valid=0, out_last=0, busy=0, overrun=0, out_data=0.
- Reset mid-transfer discards the block; no partial words are emitted after release.
- States: IDLE, SEND.
- IDLE:
  - done=1 -> capture text_out into the holding register, counter=0, go to SEND.
  - Latency: out_valid=1 in the cycle after done.
- SEND:
  - out_valid=1 and busy=1.
  - out_data = hold[BLOCK_W-1-WORD_W*cnt -: WORD_W]; word 0 = text_out[127:96].
  - out_last = (cnt == NWORDS-1).
  - Handshake on a non-last word: cnt increments.
  - Handshake on the last word, done=0: go to IDLE, cnt=0; out_valid drops next cycle.
  - Handshake on the last word, done=1 in the same cycle: capture the new block, cnt=0, stay in SEND. No bubble, no overrun.
  - done=1 in any other SEND cycle: new block dropped; the held block continues unchanged; overrun set to 1 next cycle.
- Handshake rules:
  - out_valid, once asserted, never deasserts before the handshake.
  - out_data and out_last do not change while out_valid=1 and out_ready=0.
  - out_ready is ignored while out_valid=0.
- overrun:
  - Sticky until ovr_clr=1 or reset.
  - Set and clear in the same cycle -> set wins.
- busy is combinationally equal to (state==SEND). The host uses it to gate ld.
- Throughput: one word per cycle with out_ready held high; a block drains in NWORDS cycles.
- Counter width is clog2(NWORDS), minimum 1. The counter never wraps past NWORDS-1.

Test Plan:
- Reset/idle: assert rst=0 mid-SEND with cnt=2 -> next edge after release shows out_valid=0, busy=0, overrun=0, out_data=0; no further words are emitted.
- Basic stream (FIPS-197 vector): done with text_out=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on 4 consecutive cycles starting the cycle after done; out_last only on 70b4c55a; busy low the following cycle.
- Backpressure: out_ready=0 for 3 cycles on word 1 -> out_data holds 6a7b0430 and out_valid stays 1; the stream resumes on out_ready=1 with no word lost or duplicated.
- Back-to-back: second done (text_out=00112233445566778899aabbccddeeff) in the same cycle as the last-word handshake -> next cycle out_data=00112233, no idle cycle, overrun=0.
- Overrun: second done during word 1 of the first block -> first block completes intact (all 4 words), second block never appears, overrun=1 from the next cycle. ovr_clr=1 -> overrun=0; ovr_clr=1 together with a new overrun event -> overrun stays 1.
- Parameter check with WORD_W=64 -> 2 words per block (69c4e0d86a7b0430, d8cdb78070b4c55a); out_last on the second word.
